sbus_uart_decoder: RTL and testbench
====================================

Name: sbus_uart_decoder

Overview:
- Top-level S.BUS receiver. Samples a UART line at 100 kbaud with 8 data bits, even parity and 2 stop bits (8E2).
- Reports each received byte with its error flags, echoes valid bytes on a UART transmitter and drives LEDs.
- Assembles 25-byte S.BUS frames (header, 22 data, flags, footer) into a 200-bit output with a one-cycle valid strobe.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BIT_RATE, 100000, UART baud rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE = 500.
- DATA_BITS, 8, data bits per character.
- PARITY_BIT, 1, number of parity bits (even parity).
- STOP_BITS, 2, number of stop bits.
- PAYLOAD_BITS, 11, DATA_BITS+PARITY_BIT+STOP_BITS.
- SBUS_HEADER, 8'hF0, required data value of byte 0.
- SBUS_FOOTER, 8'h00, required data value of byte 24.
- GAP_TIMEOUT_BITS, 30, idle bit-times mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- sw_0  in  1  reset; asynchronous, active-low.
- uart_rxd  in  1  UART receive line, idle high.
- led  out  8  data bits of the last valid byte.
- uart_rx_valid  out  1  one-cycle pulse per completed character.
- uart_rx_break  out  1  one-cycle pulse on a break character.
- uart_rx_fe  out  1  framing error of the last character.
- uart_rx_pe  out  1  parity error of the last character.
- uart_rx_data  out  11  raw payload; bit i is the i-th bit after start ([7:0] data, [8] parity, [10:9] stops).
- uart_tx_busy  out  1  high while the transmitter is sending.
- uart_txd  out  1  UART transmit line, idle high.
- sbus_frame  out  200  byte k in bits [8k+7:8k].
- sbus_frame_valid  out  1  one-cycle pulse when a good frame completes.

Behaviour:
- Reset (sw_0 low, asynchronous): every output 0, except uart_txd=1. Receiver, transmitter and frame FSM go idle.
- Reset mid-character or mid-frame: that character or frame is discarded; no strobes are produced.
- uart_rxd passes through a 2-FF synchronizer.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge of the synchronized line.
  - START: at CYCLES_PER_BIT/2 the line is resampled. If high (glitch), return to IDLE; otherwise go to DATA.
  - DATA: PAYLOAD_BITS samples are taken every CYCLES_PER_BIT, LSB first. The stop-bit samples are part of this payload.
  - STOP: 1 cycle, then back to IDLE.
- Character result, registered in the STOP cycle:
  - uart_rx_data and the flags update, and a one-cycle strobe is issued.
  - fe = 1 if either stop bit is 0.
  - pe = 1 if the parity bit differs from the XOR of the 8 data bits.
  - All 11 bits 0: uart_rx_break pulses instead of uart_rx_valid.
  - Otherwise uart_rx_valid pulses. It pulses even when fe or pe is set.
  - fe, pe and uart_rx_data hold until the next character.
- led loads rx_data[7:0] on a valid strobe with fe=0 and pe=0.
- TX FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. Each bit lasts CYCLES_PER_BIT.
  - An error-free valid byte received while in IDLE is transmitted in 8E2, LSB first.
  - uart_tx_busy is high from the cycle after the strobe until the end of STOP2.
  - A byte that arrives while busy is dropped.
- Frame FSM states: HUNT, COLLECT.
  - HUNT: an error-free byte equal to SBUS_HEADER is stored as byte 0, index set to 1, go to COLLECT.
  - COLLECT: each error-free byte is stored at the index, and the index increments.
  - Any fe, pe or break, or GAP_TIMEOUT_BITS bit-times without a character, returns to HUNT. No strobe is issued.
  - At byte 24: if the data equals SBUS_FOOTER, all 200 bits load into sbus_frame and sbus_frame_valid pulses one cycle later. In either case the FSM returns to HUNT.
  - sbus_frame holds its value until the next good frame.
- Latency: uart_rx_valid rises about 2 sync cycles plus ½ bit after the start of the second stop bit.

Decomposition:
- Package sbus_pkg holds:
  - the bit-format constants (DATA_BITS, PARITY_BIT, STOP_BITS, PAYLOAD_BITS);
  - SBUS_HEADER, SBUS_FOOTER, SBUS_FRAME_BYTES = 25;
  - enums for the RX, TX and frame states.
- Sub-module uart_rx_8e2 contains the synchronizer, the RX FSM and the flags. The transmitter and the frame FSM live in the top.

Test Plan:
- Send payload 11'b11001000001: uart_rx_valid pulses; rx_data = 11'h641; fe=0, pe=0; led = 8'h41; txd echoes 0x41 in 8E2; busy high for 12 bit-times.
- Send 11'b01100110001: valid pulses, fe=1, pe=0; led is unchanged and nothing is echoed.
- Send 11'b11101111110: pe=1, fe=0; no echo.
- Send header F0, 22 random even-parity bytes, C0, then 00: exactly one sbus_frame_valid pulse after the last byte; sbus_frame[7:0]=F0, [191:184]=C0, [199:192]=00; the random bytes appear at their indices.
- Same frame with a bad parity bit in byte 10: no sbus_frame_valid, and sbus_frame keeps its old value. A following clean frame then validates.
- Hold uart_rxd low for 12 bit-times: uart_rx_break pulses and uart_rx_valid does not. Pulling sw_0 low mid-byte drives all outputs to reset values with no strobe.

Source files
------------

// File: rtl/sbus_pkg.sv
// Shared definitions for the S.BUS receiver.
// Holds the 8E2 character format, the S.BUS frame delimiters and frame size,
// the state encodings of the receiver, transmitter and frame assembler, and
// an even-parity helper used on both the receive and transmit sides.
package sbus_pkg;

    localparam int DATA_BITS        = 8;
    localparam int PARITY_BIT       = 1;
    localparam int STOP_BITS        = 2;
    localparam int PAYLOAD_BITS     = DATA_BITS + PARITY_BIT + STOP_BITS;

    localparam logic [7:0] SBUS_HEADER = 8'hF0;
    localparam logic [7:0] SBUS_FOOTER = 8'h00;
    localparam int SBUS_FRAME_BYTES    = 25;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_e;

    typedef enum logic {FR_HUNT, FR_COLLECT} frame_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sbus_uart_decoder_if.sv
// Character-result bundle between the UART receiver and its consumers.
//   valid : one-cycle pulse per completed non-break character
//   brk   : one-cycle pulse per break character (all payload bits zero)
//   fe/pe : framing/parity error of the last character (held)
//   data  : raw 11-bit payload of the last character (held)
// The receiver drives it through the master modport; readers use slave.
interface sbus_uart_decoder_if;
    logic        valid;
    logic        brk;
    logic        fe;
    logic        pe;
    logic [10:0] data;

    modport master (output valid, brk, fe, pe, data);
    modport slave  (input  valid, brk, fe, pe, data);
endinterface

// File: rtl/uart_rx_8e2.sv
// 8E2 UART receiver.
// Ports: clk, rst_n (async active-low), rxd_i (raw line, idle high),
//        rx (master side of the character-result bundle).
// The line is double-synchronised; a falling edge starts a character, the
// start bit is re-checked at mid-bit to reject glitches, then all 11 payload
// bits (data, parity and both stops) are sampled at their bit centres.
module uart_rx_8e2
    import sbus_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 500
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rxd_i,
    sbus_uart_decoder_if.master         rx
);
    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    IDX_LAST = 4'(PAYLOAD_BITS - 1);

    logic                    meta_q, sync_q, prev_q;
    rx_state_e               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d, brk_q, brk_d, fe_q, fe_d, pe_q, pe_d;

    // Line synchroniser plus one extra stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Receiver state and character-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= {CW{1'b0}};
            idx_q   <= 4'd0;
            shift_q <= {PAYLOAD_BITS{1'b0}};
            data_q  <= {PAYLOAD_BITS{1'b0}};
            valid_q <= 1'b0;
            brk_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            brk_q   <= brk_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
        end
    end

    // Receiver next state; payload is shifted in from the top so the first
    // bit after start ends up in bit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        brk_d   = 1'b0;
        fe_d    = fe_q;
        pe_d    = pe_q;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = {CW{1'b0}};
                    idx_d = 4'd0;
                    if (sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    shift_d = {sync_q, shift_q[PAYLOAD_BITS-1:1]};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                state_d = RX_IDLE;
                data_d  = shift_q;
                fe_d    = ~(shift_q[9] & shift_q[10]);
                pe_d    = shift_q[8] ^ parity8(shift_q[7:0]);
                if (shift_q == {PAYLOAD_BITS{1'b0}}) begin
                    brk_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx.valid = valid_q;
    assign rx.brk   = brk_q;
    assign rx.fe    = fe_q;
    assign rx.pe    = pe_q;
    assign rx.data  = data_q;

endmodule

// File: rtl/sbus_uart_decoder.sv
// S.BUS receiver top level.
// Ports: clk; sw_0 (async active-low reset); uart_rxd (line in);
//        led (last error-free byte); uart_rx_valid/break/fe/pe/data
//        (character results); uart_tx_busy/uart_txd (8E2 echo of clean bytes);
//        sbus_frame/sbus_frame_valid (assembled 25-byte frame and its strobe).
module sbus_uart_decoder
    import sbus_pkg::*;
#(
    parameter int CLK_HZ           = 50000000,
    parameter int BIT_RATE         = 100000,
    parameter int GAP_TIMEOUT_BITS = 30
) (
    input  logic         clk,
    input  logic         sw_0,
    input  logic         uart_rxd,
    output logic [7:0]   led,
    output logic         uart_rx_valid,
    output logic         uart_rx_break,
    output logic         uart_rx_fe,
    output logic         uart_rx_pe,
    output logic [10:0]  uart_rx_data,
    output logic         uart_tx_busy,
    output logic         uart_txd,
    output logic [199:0] sbus_frame,
    output logic         sbus_frame_valid
);
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam int GAP_CYCLES = GAP_TIMEOUT_BITS * CYCLES_PER_BIT;
    localparam int GW = $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam int FRAME_W  = SBUS_FRAME_BYTES * 8;
    localparam logic [4:0] LAST_BYTE = 5'(SBUS_FRAME_BYTES - 1);

    sbus_uart_decoder_if rx_bus ();

    uart_rx_8e2 #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_rx (
        .clk   (clk),
        .rst_n (sw_0),
        .rxd_i (uart_rxd),
        .rx    (rx_bus)
    );

    logic [7:0] rx_byte_s;
    logic       good_s, err_s, char_s;

    assign rx_byte_s = rx_bus.data[7:0];
    assign good_s    = rx_bus.valid & ~rx_bus.fe & ~rx_bus.pe;
    assign err_s     = rx_bus.brk | (rx_bus.valid & (rx_bus.fe | rx_bus.pe));
    assign char_s    = rx_bus.valid | rx_bus.brk;

    logic [7:0]         led_q;
    tx_state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_idx_q, tx_idx_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               tx_par_q, tx_par_d, txd_q, txd_d, busy_q, busy_d;
    frame_state_e       fr_state_q, fr_state_d;
    logic [4:0]         fr_idx_q, fr_idx_d;
    logic [FRAME_W-9:0] fr_buf_q, fr_buf_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               fr_pend_q, fr_pend_d, frame_valid_q;

    // All top-level state: LED latch, transmitter and frame assembler.
    always_ff @(posedge clk or negedge sw_0) begin
        if (!sw_0) begin
            led_q         <= 8'h00;
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= {CW{1'b0}};
            tx_idx_q      <= 3'd0;
            tx_shift_q    <= 8'h00;
            tx_par_q      <= 1'b0;
            txd_q         <= 1'b1;
            busy_q        <= 1'b0;
            fr_state_q    <= FR_HUNT;
            fr_idx_q      <= 5'd0;
            fr_buf_q      <= {(FRAME_W-8){1'b0}};
            gap_q         <= {GW{1'b0}};
            frame_q       <= {FRAME_W{1'b0}};
            fr_pend_q     <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            led_q         <= good_s ? rx_byte_s : led_q;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_idx_q      <= tx_idx_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            txd_q         <= txd_d;
            busy_q        <= busy_d;
            fr_state_q    <= fr_state_d;
            fr_idx_q      <= fr_idx_d;
            fr_buf_q      <= fr_buf_d;
            gap_q         <= gap_d;
            frame_q       <= frame_d;
            fr_pend_q     <= fr_pend_d;
            frame_valid_q <= fr_pend_q;
        end
    end

    // Transmitter: txd is computed one bit ahead so the line register changes
    // exactly on each bit boundary and busy covers all 12 bit-times.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (good_s) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = {CW{1'b0}};
                    tx_shift_d = rx_byte_s;
                    tx_par_d   = parity8(rx_byte_s);
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    txd_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = {CW{1'b0}};
                    tx_idx_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = {CW{1'b0}};
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_PARITY;
                        txd_d      = tx_par_q;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_PARITY, TX_STOP1, TX_STOP2: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = {CW{1'b0}};
                    txd_d    = 1'b1;
                    if (tx_state_q == TX_PARITY) begin
                        tx_state_d = TX_STOP1;
                    end else if (tx_state_q == TX_STOP1) begin
                        tx_state_d = TX_STOP2;
                    end else begin
                        tx_state_d = TX_IDLE;
                        busy_d     = 1'b0;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Frame assembler: bytes 0..23 collect into a buffer; the footer check
    // on byte 24 publishes the whole frame, and the strobe follows a cycle
    // later from fr_pend_q.
    always_comb begin
        fr_state_d = fr_state_q;
        fr_idx_d   = fr_idx_q;
        fr_buf_d   = fr_buf_q;
        gap_d      = gap_q;
        frame_d    = frame_q;
        fr_pend_d  = 1'b0;
        case (fr_state_q)
            FR_HUNT: begin
                gap_d = {GW{1'b0}};
                if (good_s && (rx_byte_s == SBUS_HEADER)) begin
                    fr_buf_d[7:0] = rx_byte_s;
                    fr_idx_d      = 5'd1;
                    fr_state_d    = FR_COLLECT;
                end else begin
                    fr_state_d = FR_HUNT;
                end
            end
            FR_COLLECT: begin
                if (char_s) begin
                    gap_d = {GW{1'b0}};
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
                if (err_s) begin
                    fr_state_d = FR_HUNT;
                end else if (good_s) begin
                    if (fr_idx_q == LAST_BYTE) begin
                        fr_state_d = FR_HUNT;
                        if (rx_byte_s == SBUS_FOOTER) begin
                            frame_d   = {rx_byte_s, fr_buf_q};
                            fr_pend_d = 1'b1;
                        end else begin
                            frame_d = frame_q;
                        end
                    end else begin
                        fr_buf_d[{fr_idx_q, 3'b000} +: 8] = rx_byte_s;
                        fr_idx_d = fr_idx_q + 5'd1;
                    end
                end else if (gap_q == GAP_LAST) begin
                    fr_state_d = FR_HUNT;
                end else begin
                    fr_state_d = FR_COLLECT;
                end
            end
            default: begin
                fr_state_d = FR_HUNT;
            end
        endcase
    end

    assign led              = led_q;
    assign uart_rx_valid    = rx_bus.valid;
    assign uart_rx_break    = rx_bus.brk;
    assign uart_rx_fe       = rx_bus.fe;
    assign uart_rx_pe       = rx_bus.pe;
    assign uart_rx_data     = rx_bus.data;
    assign uart_tx_busy     = busy_q;
    assign uart_txd         = txd_q;
    assign sbus_frame       = frame_q;
    assign sbus_frame_valid = frame_valid_q;

endmodule

// File: tb/tb_sbus_uart_decoder.sv
module tb_sbus_uart_decoder;
    import sbus_pkg::*;

    localparam int CPB = 16;

    logic         clk = 1'b0;
    logic         sw_0;
    logic         uart_rxd;
    logic [7:0]   led;
    logic         uart_rx_valid, uart_rx_break, uart_rx_fe, uart_rx_pe;
    logic [10:0]  uart_rx_data;
    logic         uart_tx_busy, uart_txd;
    logic [199:0] sbus_frame;
    logic         sbus_frame_valid;

    always #5 clk = ~clk;

    sbus_uart_decoder #(.CLK_HZ(1600000), .BIT_RATE(100000), .GAP_TIMEOUT_BITS(30)) dut (
        .clk              (clk),
        .sw_0             (sw_0),
        .uart_rxd         (uart_rxd),
        .led              (led),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_break    (uart_rx_break),
        .uart_rx_fe       (uart_rx_fe),
        .uart_rx_pe       (uart_rx_pe),
        .uart_rx_data     (uart_rx_data),
        .uart_tx_busy     (uart_tx_busy),
        .uart_txd         (uart_txd),
        .sbus_frame       (sbus_frame),
        .sbus_frame_valid (sbus_frame_valid)
    );

    // Observation bundle for the receiver results.
    sbus_uart_decoder_if mon ();
    assign mon.valid = uart_rx_valid;
    assign mon.brk   = uart_rx_break;
    assign mon.fe    = uart_rx_fe;
    assign mon.pe    = uart_rx_pe;
    assign mon.data  = uart_rx_data;

    typedef struct packed {
        logic [10:0] data;
        logic        brk;
        logic        fe;
        logic        pe;
    } exp_t;

    exp_t         exp_q[$];
    logic [199:0] exp_frames[$];
    logic [10:0]  tx_got[$];
    logic [7:0]   exp_led;
    logic [7:0]   fb [25];
    int n_pass = 0, n_total = 0;
    int n_valid = 0, n_brk = 0, n_fv = 0;
    int busy_cnt = 0, busy_len = 0, busy_runs = 0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // What the receiver must report for a given payload, from the 8E2 rules.
    function automatic exp_t model_char(input logic [10:0] p);
        exp_t e;
        e.data = p;
        e.brk  = (p == 11'd0);
        e.fe   = !(p[9] && p[10]);
        e.pe   = (p[8] != (^p[7:0]));
        return e;
    endfunction

    task automatic drive_payload(input logic [10:0] p);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            uart_rxd = p[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic send_char(input logic [10:0] p);
        exp_q.push_back(model_char(p));
        drive_payload(p);
    endtask

    task automatic fill_random();
        logic [7:0] b;
        fb[0] = 8'hF0;
        for (int k = 1; k <= 22; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hF0) b = 8'h5A;
            fb[k] = b;
        end
        fb[23] = 8'hC0;
        fb[24] = 8'h00;
    endtask

    task automatic send_frame(input int bad_idx, input bit good, output logic [199:0] f);
        logic [10:0] p;
        for (int k = 0; k < 25; k++) f[8*k +: 8] = fb[k];
        if (good) exp_frames.push_back(f);
        for (int k = 0; k < 25; k++) begin
            p = {2'b11, ^fb[k], fb[k]};
            if (k == bad_idx) p[8] = ~p[8];
            send_char(p);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_led"}, led, 8'h00);
        chk({tag, "_rx_flags"}, {uart_rx_valid, uart_rx_break, uart_rx_fe, uart_rx_pe}, 4'b0000);
        chk({tag, "_rx_data"}, uart_rx_data, 11'h000);
        chk({tag, "_tx"}, {uart_tx_busy, uart_txd}, 2'b01);
        chk({tag, "_frame"}, sbus_frame, 200'd0);
        chk({tag, "_frame_valid"}, sbus_frame_valid, 1'b0);
    endtask

    // Per-cycle compare of receiver strobes and frame strobes against the model.
    always @(negedge clk) begin
        exp_t e;
        if (sw_0 === 1'b1) begin
            if (mon.valid || mon.brk) begin
                chk("rx_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rx_kind", {mon.valid, mon.brk}, {~e.brk, e.brk});
                    chk("rx_data", mon.data, e.data);
                    chk("rx_fe", mon.fe, e.fe);
                    chk("rx_pe", mon.pe, e.pe);
                    chk("led_before_update", led, exp_led);
                    if (!e.brk && !e.fe && !e.pe) exp_led = e.data[7:0];
                end
                if (mon.valid) n_valid++;
                if (mon.brk) n_brk++;
            end
            if (sbus_frame_valid) begin
                chk("frame_pending", exp_frames.size() > 0, 1'b1);
                if (exp_frames.size() > 0) chk("sbus_frame", sbus_frame, exp_frames.pop_front());
                n_fv++;
            end
        end
    end

    // Decode whatever the transmitter puts on uart_txd.
    always @(negedge clk) begin
        logic [10:0] w;
        if (sw_0 === 1'b1 && uart_txd === 1'b0) begin
            repeat (CPB / 2 - 1) @(negedge clk);
            for (int i = 0; i < 11; i++) begin
                repeat (CPB) @(negedge clk);
                w[i] = uart_txd;
            end
            tx_got.push_back(w);
        end
    end

    // Measure the length of each busy episode.
    always @(negedge clk) begin
        if (uart_tx_busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            busy_len  = busy_cnt;
            busy_runs++;
            busy_cnt  = 0;
        end
    end

    initial begin
        logic [199:0] f1, f2, f3;
        int runs0, v0, b0;
        sw_0 = 1'b0;
        uart_rxd = 1'b1;
        exp_led = 8'h00;
        repeat (4) @(negedge clk);
        chk_reset_outputs("reset");
        sw_0 = 1'b1;
        repeat (40) @(negedge clk);

        // Clean byte 0x41: reported, lit on the LEDs, echoed.
        tx_got.delete();
        runs0 = busy_runs;
        send_char(11'b11001000001);
        chk("b1_data", uart_rx_data, 11'h641);
        chk("b1_fe_pe", {uart_rx_fe, uart_rx_pe}, 2'b00);
        chk("b1_led", led, 8'h41);
        chk("b1_valid_count", n_valid, 1);
        repeat (14 * CPB) @(negedge clk);
        chk("echo_count", tx_got.size(), 1);
        if (tx_got.size() > 0) chk("echo_word", tx_got[0], 11'h641);
        chk("busy_runs", busy_runs - runs0, 1);
        chk("busy_len", busy_len, 12 * CPB);

        // Framing error, then parity error: reported, no LED change, no echo.
        tx_got.delete();
        runs0 = busy_runs;
        send_char(11'b01100110001);
        chk("fe_byte_flags", {uart_rx_fe, uart_rx_pe}, 2'b10);
        chk("fe_byte_led", led, 8'h41);
        chk("fe_valid_count", n_valid, 2);
        repeat (2 * CPB) @(negedge clk);
        send_char(11'b11101111110);
        chk("pe_byte_flags", {uart_rx_fe, uart_rx_pe}, 2'b01);
        chk("pe_byte_led", led, 8'h41);
        repeat (14 * CPB) @(negedge clk);
        chk("no_echo", tx_got.size(), 0);
        chk("no_busy", busy_runs - runs0, 0);

        // Good frame.
        fill_random();
        send_frame(-1, 1'b1, f1);
        repeat (40 * CPB) @(negedge clk);
        chk("frame1_strobes", n_fv, 1);
        chk("frame1_header", sbus_frame[7:0], 8'hF0);
        chk("frame1_byte23", sbus_frame[191:184], 8'hC0);
        chk("frame1_footer", sbus_frame[199:192], 8'h00);
        chk("frame1_byte5", sbus_frame[47:40], fb[5]);

        // Same frame with a parity error in byte 10: no strobe, frame held.
        send_frame(10, 1'b0, f2);
        repeat (40 * CPB) @(negedge clk);
        chk("frame2_strobes", n_fv, 1);
        chk("frame2_held", sbus_frame, f1);

        // Fresh clean frame validates.
        fill_random();
        send_frame(-1, 1'b1, f3);
        repeat (40 * CPB) @(negedge clk);
        chk("frame3_strobes", n_fv, 2);
        chk("frame3_value", sbus_frame, f3);

        // Reset in the middle of a frame, partway through a byte.
        for (int k = 0; k < 4; k++) send_char({2'b11, ^fb[k], fb[k]});
        v0 = n_valid;
        uart_rxd = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        sw_0 = 1'b0;
        uart_rxd = 1'b1;
        exp_led = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midbyte_reset");
        repeat (20) @(negedge clk);
        sw_0 = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        chk("reset_no_strobe", n_valid, v0);
        chk("reset_pending", exp_q.size(), 0);
        chk("reset_frame_held", sbus_frame, 200'd0);

        // Frame after reset.
        fill_random();
        send_frame(-1, 1'b1, f1);
        repeat (40 * CPB) @(negedge clk);
        chk("frame4_strobes", n_fv, 3);

        // Break: line low for 12 bit-times.
        v0 = n_valid;
        b0 = n_brk;
        send_char(11'd0);
        repeat (4 * CPB) @(negedge clk);
        chk("break_pulses", n_brk - b0, 1);
        chk("break_no_valid", n_valid - v0, 0);
        chk("break_flags", {uart_rx_fe, uart_rx_pe, uart_rx_data}, {1'b1, 1'b0, 11'h000});

        chk("all_chars_seen", exp_q.size(), 0);
        chk("all_frames_seen", exp_frames.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
